fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Sequences the program counter and the instruction-fetch handshake. Drives pc_next/pc_branch of
//  program_counter (which self-increments by 4 unless pc_branch=1), so it holds, advances or
//  redirects the PC. Arbitrates redirect sources (trap > mret > ex_redirect) and drops stale fetch
//  responses. Sits between the PC register, instruction memory and decode.
// PARAMETERS
//  XLEN     64  PC/address width
//  ILEN     32  instruction width
//  NOP_INSN 32'h0000_0013  if_instr value while if_valid=0
// PORTS
//  clk          in   1     clock
//  reset        in   1     reset, asynchronous, active-high
//  pc_cur       in   XLEN  program_counter pc_out
//  pc_next      out  XLEN  value loaded into PC when pc_branch=1
//  pc_branch    out  1     1 = load pc_next; 0 = PC advances by 4
//  imem_req     out  1     fetch request, held until imem_gnt
//  imem_addr    out  XLEN  fetch address (= pc_cur)
//  imem_gnt     in   1     request accepted this cycle
//  imem_rvalid  in   1     response valid; exactly one per grant, in order
//  imem_rdata   in   ILEN  response instruction
//  if_valid     out  1     instruction available to decode
//  if_instr     out  ILEN  instruction
//  if_pc        out  XLEN  address of if_instr
//  if_ready     in   1     decode accepts when if_valid && if_ready
//  trap_req     in   1     take trap, target trap_vec
//  trap_vec     in   XLEN  trap target
//  mret_req     in   1     return, target mret_epc
//  mret_epc     in   XLEN  return target
//  ex_redirect  in   1     taken branch/jump, target ex_target
//  ex_target    in   XLEN  branch/jump target
//  halt_req     in   1     level: stop fetching
//  flush        out  1     1-cycle pulse: younger pipeline stages must squash
//  misalign_err out  1     1-cycle pulse: winning target had [1:0]!=0
// BEHAVIOUR
//  States: BOOT, FETCH, WAIT, DRAIN, HALTED. Reset -> BOOT; all outputs 0 (if_instr=NOP_INSN).
//  Default pc_branch=1, pc_next=pc_cur (hold). pc_branch=0 only in the imem_gnt cycle, no redirect.
//  BOOT: 1 cycle, no request, rvalid ignored -> FETCH.
//  FETCH: imem_req=1 iff output buffer empty or drained this cycle (if_ready); gnt -> latch
//   fetch_pc=pc_cur, PC advances, -> WAIT. halt_req && no grant -> HALTED.
//  WAIT: rvalid -> buffer {imem_rdata, fetch_pc}, if_valid=1 next cycle, -> FETCH.
//  DRAIN: stale response outstanding; rvalid discarded -> FETCH. No new request.
//  HALTED: hold PC, no request; leave to FETCH on !halt_req or any redirect.
//  Redirect (any state but BOOT): winner by trap > mret > ex_redirect; same cycle pc_branch=1,
//   pc_next=target with [1:0] forced to 0, flush=1, buffered instruction discarded (if_valid=0 next
//   cycle). Next: DRAIN if a grant is outstanding (WAIT, or gnt this cycle), else FETCH.
//  misalign_err pulses with the redirect when winning target[1:0]!=0.
//  Redirect + rvalid same cycle in WAIT: response discarded, -> FETCH.
//  Buffer held stable while if_valid && !if_ready. At most one grant outstanding.
//  Async reset mid-operation: immediate return to BOOT; memory shares reset.
// STRUCTURE
//  rv_core_pkg: fetch state enum, XLEN/ILEN, NOP_INSN, redirect-source enum
//   {RD_NONE,RD_TRAP,RD_MRET,RD_EX}.
//  One sub-module: fetch_out_buf (1-entry valid/ready register, flush input).
// TESTING
//  Zero-wait memory, if_ready=1: pc 0,4,8 fetched; if_pc sequence 0,4,8, one instr / 2 cycles.
//  imem_gnt low 3 cycles: pc_branch=1, pc_next=pc_cur, PC stays 0x0 until grant.
//  ex_redirect target 0x100 in WAIT: flush=1, response dropped, next if_pc=0x100.
//  trap_req(0x8000) + ex_redirect(0x200) same cycle -> pc_next=0x8000; ex_target 0x102 -> 0x100 + misalign_err.
//  if_ready=0 for 5 cycles: if_instr/if_pc stable, imem_req=0, PC held.
//  halt_req with fetch outstanding: response delivered, HALTED; mret_req(0x40) -> next if_pc=0x40.

Source files
------------

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer: widths, the fetch FSM
// state set and the redirect-source priority helper.
package fetch_pc_sequencer_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_HALTED
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_TRAP,
    RD_MRET,
    RD_EX
  } redir_src_e;

  // Traps outrank returns, which outrank ordinary branch/jump redirects.
  function automatic redir_src_e pickRedirect(input logic trap, input logic mret, input logic ex);
    if (trap) return RD_TRAP;
    if (mret) return RD_MRET;
    if (ex) return RD_EX;
    return RD_NONE;
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_out_buf.sv
// One-entry valid/ready holding register between instruction memory and decode;
// a flush discards whatever it holds.
module fetch_pc_sequencer_out_buf
  import fetch_pc_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush wins over a same-cycle load so a squashed response never reaches decode.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSN;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = valid_q ? instr_q : NOP_INSN;
  assign pc_o    = valid_q ? pc_q : '0;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Steers the external PC register (hold / advance / redirect), runs the single-
// outstanding fetch handshake and drops responses made stale by a redirect.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_cur_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_branch_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [ILEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            if_ready_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mret_epc_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            halt_req_i,
  output logic            flush_o,
  output logic            misalign_err_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  redir_src_e      redirSrc;
  logic            redirect;
  logic [XLEN-1:0] rawTarget;
  logic            bufValid;
  logic            canAccept;
  logic            gntFire;
  logic            outstanding;
  logic            bufLoad;

  // Redirects are ignored for the single boot cycle.
  always_comb begin
    redirSrc = RD_NONE;
    if (state_q != ST_BOOT) redirSrc = pickRedirect(trap_req_i, mret_req_i, ex_redirect_i);
    redirect = (redirSrc != RD_NONE);
    case (redirSrc)
      RD_TRAP: rawTarget = trap_vec_i;
      RD_MRET: rawTarget = mret_epc_i;
      RD_EX:   rawTarget = ex_target_i;
      default: rawTarget = pc_cur_i;
    endcase
  end

  assign canAccept   = !bufValid || if_ready_i;
  assign imem_req_o  = (state_q == ST_FETCH) && canAccept && !halt_req_i;
  assign imem_addr_o = pc_cur_i;
  assign gntFire     = imem_req_o && imem_gnt_i;
  assign outstanding = (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !imem_rvalid_i) || gntFire;
  assign bufLoad     = (state_q == ST_WAIT) && imem_rvalid_i && !redirect;

  assign pc_branch_o    = !(gntFire && !redirect);
  assign pc_next_o      = redirect ? {rawTarget[XLEN-1:2], 2'b00} : pc_cur_i;
  assign flush_o        = redirect;
  assign misalign_err_o = redirect && (rawTarget[1:0] != 2'b00);

  // A redirect with a grant still in flight must first swallow that response.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = gntFire ? pc_cur_i : fetchPc_q;
    if (redirect) begin
      state_d = outstanding ? ST_DRAIN : ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT:   state_d = ST_FETCH;
        ST_FETCH:  if (gntFire) state_d = ST_WAIT;
                   else if (halt_req_i) state_d = ST_HALTED;
        ST_WAIT:   if (imem_rvalid_i) state_d = ST_FETCH;
        ST_DRAIN:  if (imem_rvalid_i) state_d = ST_FETCH;
        ST_HALTED: if (!halt_req_i) state_d = ST_FETCH;
        default:   state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      fetchPc_q <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
    end
  end

  fetch_pc_sequencer_out_buf u_outBuf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (bufLoad),
    .instr_i (imem_rdata_i),
    .pc_i    (fetchPc_q),
    .flush_i (redirect),
    .ready_i (if_ready_i),
    .valid_o (bufValid),
    .instr_o (if_instr_o),
    .pc_o    (if_pc_o)
  );

  assign if_valid_o = bufValid;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Randomised bench: models the PC register and instruction memory, and scores the
// decode-side instruction stream and redirect pulses against program-order rules.
module tb_fetch_pc_sequencer;
  import fetch_pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pcCur = '0;
  logic [63:0] pcNext;
  logic        pcBranch;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = '0;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [63:0] ifPc;
  logic        ifReady = 1'b1;
  logic        trapReq = 1'b0, mretReq = 1'b0, exRedirect = 1'b0, haltReq = 1'b0;
  logic [63:0] trapVec = '0, mretEpc = '0, exTarget = '0;
  logic        flush, misalignErr;

  fetch_pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur_i(pcCur), .pc_next_o(pcNext), .pc_branch_o(pcBranch),
    .imem_req_o(imemReq), .imem_addr_o(imemAddr), .imem_gnt_i(imemGnt),
    .imem_rvalid_i(imemRvalid), .imem_rdata_i(imemRdata), .if_valid_o(ifValid),
    .if_instr_o(ifInstr), .if_pc_o(ifPc), .if_ready_i(ifReady), .trap_req_i(trapReq),
    .trap_vec_i(trapVec), .mret_req_i(mretReq), .mret_epc_i(mretEpc),
    .ex_redirect_i(exRedirect), .ex_target_i(exTarget), .halt_req_i(haltReq),
    .flush_o(flush), .misalign_err_o(misalignErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] target;
    logic        misalign;
  } redir_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  redir_t      redirQ[$];
  logic [63:0] expPc = '0;
  int          hsCount = 0;
  int          lastHsCycle = -1;
  bit          checkSpacing = 0;
  bit          grantSeen = 0;
  bit          memGntEn = 0;
  bit          memRandGnt = 0;
  int          memMinLat = 0;
  int          memMaxLat = 0;
  bit          pending = 0;
  int          lat = 0;
  logic [63:0] paddr = '0;

  function automatic logic [31:0] memData(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] randTarget();
    logic [63:0] t;
    t[63:32] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
    t[31:0]  = 32'($urandom_range(0, 32'hFFFF));
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Drives the three redirect sources for one cycle and queues the expected redirect.
  task automatic applyStimulus(input bit t, input logic [63:0] tv, input bit m,
                               input logic [63:0] mv, input bit e, input logic [63:0] ev);
    logic [63:0] tgt;
    redir_t      r;
    trapReq = t; trapVec = tv; mretReq = m; mretEpc = mv; exRedirect = e; exTarget = ev;
    if (t || m || e) begin
      tgt = t ? tv : (m ? mv : ev);
      r.target = {tgt[63:2], 2'b00};
      r.misalign = (tgt[1:0] != 2'b00);
      redirQ.push_back(r);
      expPc = r.target;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRedirect();
    nextCycle();
    applyStimulus(0, randTarget(), 0, randTarget(), 0, randTarget());
  endtask

  task automatic waitHs(input int n, input int budget);
    int target;
    target = hsCount + n;
    for (int i = 0; i < budget && hsCount < target; i++) nextCycle();
    checkOutput("hsProgress", 64'(hsCount >= target), 64'd1);
  endtask

  task automatic waitGrant(input int budget);
    grantSeen = 0;
    for (int i = 0; i < budget && !grantSeen; i++) nextCycle();
    checkOutput("grantSeen", 64'(grantSeen), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // PC register plant: load pc_next on pc_branch, else advance by 4.
  initial begin
    logic [63:0] nxt;
    forever begin
      @(negedge clk);
      nxt = reset ? 64'h0 : (pcBranch ? pcNext : pcCur + 64'd4);
      @(posedge clk);
      #1;
      if (!reset) pcCur = nxt;
    end
  end

  // Memory bookkeeping: record grants and retire responses.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      pending = 0;
    end else begin
      if (imemRvalid) pending = 0;
      if (imemReq && imemGnt) begin
        pending = 1;
        paddr = imemAddr;
        lat = $urandom_range(memMinLat, memMaxLat);
      end
    end
  end

  // Memory drive: one in-order response per grant after a random latency.
  initial forever begin
    @(posedge clk);
    #2;
    imemRvalid = 1'b0;
    imemRdata = $urandom;
    if (reset) begin
      imemGnt = 1'b0;
    end else begin
      if (pending) begin
        if (lat == 0) begin
          imemRvalid = 1'b1;
          imemRdata = memData(paddr);
        end else begin
          lat--;
        end
      end
      imemGnt = imemReq && !pending && memGntEn && (!memRandGnt || $urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops queued redirects on flush and scores every decode handshake.
  initial begin
    bit          prevStall;
    logic [31:0] prevInstr;
    logic [63:0] prevPc;
    bit          fire;
    redir_t      r;
    prevStall = 0;
    prevInstr = '0;
    prevPc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 0;
      end else begin
        fire = imemReq && imemGnt;
        if (fire) grantSeen = 1;
        if (flush) begin
          checkOutput("flushExpected", 64'(redirQ.size()), 64'd1);
          if (redirQ.size() > 0) begin
            r = redirQ.pop_front();
            checkOutput("redirTarget", pcNext, r.target);
            checkOutput("misalignErr", 64'(misalignErr), 64'(r.misalign));
            checkOutput("redirBranch", 64'(pcBranch), 64'd1);
          end
          prevStall = 0;
        end else begin
          checkOutput("flushMissing", 64'(redirQ.size()), 64'd0);
          redirQ.delete();
          checkOutput("misalignIdle", 64'(misalignErr), 64'd0);
          if (fire) begin
            checkOutput("advanceOnGnt", 64'(pcBranch), 64'd0);
          end else begin
            checkOutput("holdBranch", 64'(pcBranch), 64'd1);
            checkOutput("holdPcNext", pcNext, pcCur);
          end
          if (prevStall) begin
            checkOutput("stallValid", 64'(ifValid), 64'd1);
            checkOutput("stallInstr", 64'(ifInstr), 64'(prevInstr));
            checkOutput("stallPc", ifPc, prevPc);
          end
          if (ifValid && ifReady) begin
            checkOutput("ifPc", ifPc, expPc);
            checkOutput("ifInstr", 64'(ifInstr), 64'(memData(expPc)));
            if (checkSpacing && lastHsCycle >= 0)
              checkOutput("hsSpacing", 64'(cycle - lastHsCycle), 64'd2);
            lastHsCycle = cycle;
            hsCount++;
            expPc = expPc + 64'd4;
          end
          prevStall = ifValid && !ifReady;
          prevInstr = ifInstr;
          prevPc = ifPc;
        end
        if (imemReq) checkOutput("imemAddr", imemAddr, pcCur);
        if (ifValid && !ifReady) checkOutput("reqWhileFull", 64'(imemReq), 64'd0);
        if (!ifValid) checkOutput("nopWhenIdle", 64'(ifInstr), 64'(NOP_INSN));
      end
    end
  end

  initial begin
    #200000;
    $fatal(1, "[TB] FAIL watchdog: simulation did not finish");
  end

  initial begin
    logic [63:0] savedPc;
    int          hsBefore;
    bit          t, m, e;

    #12;
    checkOutput("rstValid", 64'(ifValid), 64'd0);
    checkOutput("rstInstr", 64'(ifInstr), 64'(NOP_INSN));
    checkOutput("rstIfPc", ifPc, 64'd0);
    checkOutput("rstReq", 64'(imemReq), 64'd0);
    checkOutput("rstFlush", 64'(flush), 64'd0);
    checkOutput("rstMisalign", 64'(misalignErr), 64'd0);
    checkOutput("rstPcNext", pcNext, 64'd0);
    #11 reset = 1'b0;

    // Grant withheld: PC must stay at the reset vector with the request held.
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("pcStallNoGnt", pcCur, 64'd0);
    checkOutput("reqHeldNoGnt", 64'(imemReq), 64'd1);
    nextCycle();
    memGntEn = 1;
    checkSpacing = 1;
    waitHs(3, 40);
    checkSpacing = 0;

    // Branch redirect while a response is still outstanding.
    memMinLat = 2; memMaxLat = 2;
    waitGrant(40);
    applyStimulus(0, 64'h0, 0, 64'h0, 1, 64'h100);
    clearRedirect();
    waitHs(2, 60);

    memMinLat = 0; memMaxLat = 1;
    nextCycle();
    applyStimulus(1, 64'h8000, 0, 64'h0, 1, 64'h200);
    clearRedirect();
    waitHs(1, 60);
    applyStimulus(0, 64'h0, 0, 64'h0, 1, 64'h102);
    clearRedirect();
    waitHs(2, 60);

    // Decode back-pressure.
    memMinLat = 0; memMaxLat = 0;
    ifReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    savedPc = pcCur;
    repeat (5) @(negedge clk);
    checkOutput("stallPcHeld", pcCur, savedPc);
    checkOutput("stallBufFull", 64'(ifValid), 64'd1);
    checkOutput("stallNoReq", 64'(imemReq), 64'd0);
    nextCycle();
    ifReady = 1'b1;
    waitHs(1, 40);

    // Halt with a fetch in flight, then leave via mret.
    memMinLat = 1; memMaxLat = 1;
    waitGrant(40);
    haltReq = 1'b1;
    hsBefore = hsCount;
    repeat (4) @(posedge clk);
    @(negedge clk);
    savedPc = pcCur;
    repeat (4) @(negedge clk);
    checkOutput("haltDelivered", 64'(hsCount > hsBefore), 64'd1);
    checkOutput("haltNoReq", 64'(imemReq), 64'd0);
    checkOutput("haltPcHeld", pcCur, savedPc);
    nextCycle();
    applyStimulus(0, 64'h0, 1, 64'h40, 0, 64'h0);
    clearRedirect();
    haltReq = 1'b0;
    waitHs(1, 40);

    // Randomised traffic.
    memRandGnt = 1; memMinLat = 0; memMaxLat = 3;
    for (int c = 0; c < 1500; c++) begin
      nextCycle();
      ifReady = ($urandom_range(0, 3) != 0);
      if (haltReq) begin
        if ($urandom_range(0, 4) == 0) haltReq = 1'b0;
      end else if ($urandom_range(0, 30) == 0) begin
        haltReq = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) begin
        t = 1'($urandom_range(0, 1));
        m = 1'($urandom_range(0, 1));
        e = 1'($urandom_range(0, 1));
        if (!(t || m || e)) e = 1;
        applyStimulus(t, randTarget(), m, randTarget(), e, randTarget());
      end else begin
        applyStimulus(0, randTarget(), 0, randTarget(), 0, randTarget());
      end
    end
    nextCycle();
    applyStimulus(0, 64'h0, 0, 64'h0, 0, 64'h0);
    haltReq = 1'b0;
    ifReady = 1'b1;
    waitHs(2, 80);
    checkOutput("liveness", 64'(hsCount > 100), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("midRstValid", 64'(ifValid), 64'd0);
    checkOutput("midRstReq", 64'(imemReq), 64'd0);
    checkOutput("midRstInstr", 64'(ifInstr), 64'(NOP_INSN));
    checkOutput("midRstFlush", 64'(flush), 64'd0);
    redirQ.delete();
    expPc = '0;
    pcCur = '0;
    lastHsCycle = -1;
    memRandGnt = 0; memMinLat = 0; memMaxLat = 0;
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b0;
    waitHs(3, 40);
    checkOutput("queueDrained", 64'(redirQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
